// File: rtl/io_cell_cfg_sequencer.sv
// IO cell configuration sequencer: software stages per-cell shadow values over a
// register port, and a commit applies them to the active bus one cell at a time.
module io_cell_cfg_sequencer #(
    parameter int                    NUM_CELLS     = 25,
    parameter int                    CONF_WIDTH    = 5,
    parameter int                    SETTLE_CYCLES = 4,
    parameter logic [CONF_WIDTH-1:0] DEFAULT_CFG   = '0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            reg_req,
    input  logic                            reg_we,
    input  logic [5:0]                      reg_addr,
    input  logic [31:0]                     reg_wdata,
    output logic [31:0]                     reg_rdata,
    output logic                            reg_ack,
    output logic [NUM_CELLS*CONF_WIDTH-1:0] cell_cfg_o,
    output logic                            busy_o,
    output logic                            done_o
);

    localparam int                CNT_W       = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD    = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [4:0]        LAST_IDX    = 5'(NUM_CELLS - 1);
    localparam logic [5:0]        CELLS_A     = 6'(NUM_CELLS);
    localparam logic [5:0]        ADDR_CTRL   = 6'd32;
    localparam logic [5:0]        ADDR_STATUS = 6'd33;

    typedef enum logic [1:0] {IDLE, APPLY, SETTLE} state_t;

    state_t                  state_q, state_d;
    logic [4:0]              idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    done_q, done_d;
    logic                    apply_en, adv, last, busy;
    logic                    access, commit, shadow_wr, err_event, err_q, pending;
    logic [31:0]             read_data, status;
    logic [CONF_WIDTH-1:0]   shadow [NUM_CELLS];
    logic [CONF_WIDTH-1:0]   active [NUM_CELLS];
    logic                    wdata_unused;

    assign wdata_unused = ^reg_wdata[31:CONF_WIDTH];

    assign busy      = (state_q != IDLE);
    assign access    = reg_req && !reg_ack;
    assign commit    = access && reg_we && (reg_addr == ADDR_CTRL) && reg_wdata[0];
    assign shadow_wr = access && reg_we && (reg_addr < CELLS_A);
    assign err_event = (commit || shadow_wr) && busy;
    assign last      = (idx_q == LAST_IDX);
    assign busy_o    = busy;
    assign done_o    = done_q;

    always_comb begin
        pending = 1'b0;
        for (int unsigned k = 0; k < NUM_CELLS; k++) begin
            if (shadow[k] != active[k]) pending = 1'b1;
        end
    end

    always_comb begin
        cell_cfg_o = '0;
        for (int unsigned k = 0; k < NUM_CELLS; k++) begin
            cell_cfg_o[k*CONF_WIDTH +: CONF_WIDTH] = active[k];
        end
    end

    assign status = {19'b0, idx_q, 5'b0, err_q, pending, busy};

    always_comb begin
        read_data = '0;
        if (reg_addr < CELLS_A) begin
            read_data = 32'(shadow[reg_addr[4:0]]);
        end else if (reg_addr == ADDR_STATUS) begin
            read_data = status;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        apply_en = 1'b0;
        done_d   = 1'b0;
        adv      = 1'b0;
        case (state_q)
            IDLE: begin
                if (commit) begin
                    state_d = APPLY;
                    idx_d   = '0;
                end
            end
            APPLY: begin
                if (shadow[idx_q] != active[idx_q]) begin
                    apply_en = 1'b1;
                    if (SETTLE_CYCLES != 0) begin
                        cnt_d   = CNT_LOAD;
                        state_d = SETTLE;
                    end else begin
                        adv = 1'b1;
                    end
                end else begin
                    adv = 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) adv = 1'b1;
                else             cnt_d = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Shared exit path for unchanged cells, zero-settle builds and expired settle gaps.
        if (adv) begin
            if (last) begin
                state_d = IDLE;
                idx_d   = '0;
                done_d  = 1'b1;
            end else begin
                state_d = APPLY;
                idx_d   = idx_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NUM_CELLS; k++) active[k] <= DEFAULT_CFG;
        end else if (apply_en) begin
            active[idx_q] <= shadow[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_ack   <= 1'b0;
            reg_rdata <= '0;
            err_q     <= 1'b0;
            for (int unsigned k = 0; k < NUM_CELLS; k++) shadow[k] <= DEFAULT_CFG;
        end else begin
            reg_ack   <= access;
            reg_rdata <= (access && !reg_we) ? read_data : '0;
            if (shadow_wr && !busy) begin
                shadow[reg_addr[4:0]] <= reg_wdata[CONF_WIDTH-1:0];
            end
            // An error on the same edge as a STATUS read keeps err set.
            if (err_event) begin
                err_q <= 1'b1;
            end else if (access && !reg_we && reg_addr == ADDR_STATUS) begin
                err_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_io_cell_cfg_sequencer.sv
// Directed bench for io_cell_cfg_sequencer: default build (settle 4) plus a
// zero-settle build sharing the same register bus.
module tb_io_cell_cfg_sequencer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         reg_req = 1'b0;
    logic         reg_we = 1'b0;
    logic [5:0]   reg_addr = '0;
    logic [31:0]  reg_wdata = '0;
    logic [31:0]  rdata, rdata0;
    logic         ack, ack0, busy, busy0, done, done0;
    logic [124:0] cfg, cfg0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ack_cyc = 0;

    int n_chg[2], first_chg[2], last_chg[2], min_gap[2], max_gap[2];
    int multi[2], done_cnt[2], done_cyc[2], busy_cnt[2];
    logic done_busy[2];
    logic [124:0] prev[2];

    io_cell_cfg_sequencer dut (
        .clk(clk), .rst_n(rst_n), .reg_req(reg_req), .reg_we(reg_we),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(rdata), .reg_ack(ack),
        .cell_cfg_o(cfg), .busy_o(busy), .done_o(done)
    );

    io_cell_cfg_sequencer #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .reg_req(reg_req), .reg_we(reg_we),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(rdata0), .reg_ack(ack0),
        .cell_cfg_o(cfg0), .busy_o(busy0), .done_o(done0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic mon(input int d, input logic [124:0] cur, input logic dn, input logic bz);
        int nc = 0;
        for (int k = 0; k < 25; k++) if (cur[k*5 +: 5] !== prev[d][k*5 +: 5]) nc++;
        if (nc > 1) multi[d]++;
        if (nc > 0) begin
            if (n_chg[d] == 0) first_chg[d] = cyc;
            else begin
                if (cyc - last_chg[d] < min_gap[d]) min_gap[d] = cyc - last_chg[d];
                if (cyc - last_chg[d] > max_gap[d]) max_gap[d] = cyc - last_chg[d];
            end
            last_chg[d] = cyc;
            n_chg[d] += nc;
        end
        if (dn) begin
            done_cnt[d]++;
            done_cyc[d]  = cyc;
            done_busy[d] = bz;
        end
        if (bz) busy_cnt[d]++;
        prev[d] = cur;
    endtask

    always @(negedge clk) begin
        mon(0, cfg, done, busy);
        mon(1, cfg0, done0, busy0);
    end

    task automatic clr_stats();
        for (int d = 0; d < 2; d++) begin
            n_chg[d] = 0; multi[d] = 0; done_cnt[d] = 0; busy_cnt[d] = 0;
            min_gap[d] = 1000000; max_gap[d] = 0; first_chg[d] = -1; done_cyc[d] = -1;
            done_busy[d] = 1'bx;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic we, input logic [5:0] a, input logic [31:0] wd,
                          output logic [31:0] rd);
        int n = 0;
        @(negedge clk);
        reg_req = 1'b1; reg_we = we; reg_addr = a; reg_wdata = wd;
        do begin
            @(posedge clk); #1; n++;
        end while (!ack && n < 4);
        check("ack", 32'(ack), 32'd1);
        rd = rdata;
        ack_cyc = cyc;
        reg_req = 1'b0; reg_we = 1'b0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] wd);
        logic [31:0] dummy;
        access(1'b1, a, wd, dummy);
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        access(1'b0, a, 32'h0, d);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            @(posedge clk); #1; n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
        @(negedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  v;
        logic [124:0] exp_cfg;
        int           c0, bad, dsave;

        clr_stats();
        prev[0] = '0; prev[1] = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cfg", 32'(cfg == '0), 32'd1);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 25; k++) begin
            rd(6'(k), v);
            if (v !== 32'd0) bad++;
        end
        check("rst_shadow_reads", bad, 0);
        rd(6'd33, v);
        check("rst_status", v, 32'h0000_0000);
        rd(6'd40, v);
        check("unmapped_read", v, 32'd0);

        // Two changed cells
        wr(6'd3, 32'hFFFF_FFFA);
        wr(6'd24, 32'h0000_0007);
        rd(6'd3, v);
        check("shadow3_read", v, 32'h1A);
        rd(6'd33, v);
        check("status_pending", v, 32'h0000_0002);
        clr_stats();
        wr(6'd32, 32'h1);
        c0 = ack_cyc;
        check("commit_busy", 32'(busy), 32'd1);
        wait_idle(200);
        check("t2_n_chg", n_chg[0], 2);
        check("t2_first_chg", first_chg[0], c0 + 4);
        check("t2_last_chg", last_chg[0], c0 + 29);
        check("t2_done_cyc", done_cyc[0], c0 + 33);
        check("t2_done_cnt", done_cnt[0], 1);
        check("t2_done_busy", 32'(done_busy[0]), 32'd0);
        check("t2_busy_cnt", busy_cnt[0], 33);
        exp_cfg = '0; exp_cfg[15 +: 5] = 5'h1A; exp_cfg[120 +: 5] = 5'h07;
        check("t2_cfg", 32'(cfg === exp_cfg), 32'd1);
        rd(6'd33, v);
        check("t2_status_after", v & 32'h7, 32'h0);

        // All cells changed, with illegal accesses during busy
        for (int k = 0; k < 25; k++) wr(6'(k), 32'(k + 1));
        clr_stats();
        wr(6'd32, 32'h1);
        c0 = ack_cyc;
        wr(6'd0, 32'h1F);
        wr(6'd32, 32'h1);
        rd(6'd33, v);
        check("t4_status_err", v & 32'h7, 32'h7);
        rd(6'd33, v);
        check("t4_status_err_clr", v & 32'h7, 32'h3);
        wait_idle(300);
        check("t3_n_chg", n_chg[0], 25);
        check("t3_multi", multi[0], 0);
        check("t3_first_chg", first_chg[0], c0 + 1);
        check("t3_min_gap", min_gap[0], 5);
        check("t3_max_gap", max_gap[0], 5);
        check("t3_busy_cnt", busy_cnt[0], 125);
        check("t3_done_cyc", done_cyc[0], c0 + 125);
        check("t3_done_cnt", done_cnt[0], 1);
        exp_cfg = '0;
        for (int k = 0; k < 25; k++) exp_cfg[k*5 +: 5] = 5'(k + 1);
        check("t3_cfg", 32'(cfg === exp_cfg), 32'd1);
        rd(6'd0, v);
        check("t4_shadow0_kept", v, 32'h1);

        // Reset mid-sequence at idx 10
        for (int k = 0; k < 25; k++) wr(6'(k), 32'(k + 2));
        clr_stats();
        wr(6'd32, 32'h1);
        c0 = ack_cyc;
        while (cyc < c0 + 51) @(negedge clk);
        rd(6'd33, v);
        check("t5_status_idx10", v, 32'h0000_0A03);
        @(negedge clk);
        dsave = done_cnt[0];
        rst_n = 1'b0;
        #1;
        check("t5_cfg_default", 32'(cfg === '0), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        check("t5_no_done", done_cnt[0], dsave);
        rst_n = 1'b1;
        @(negedge clk);
        clr_stats();
        rd(6'd33, v);
        check("t5_status_after_rst", v, 32'h0);
        rd(6'd5, v);
        check("t5_shadow_default", v, 32'h0);
        wr(6'd32, 32'h1);
        c0 = ack_cyc;
        wait_idle(100);
        check("t5_nop_done_cyc", done_cyc[0], c0 + 25);
        check("t5_nop_n_chg", n_chg[0], 0);
        check("t5_nop_done_cnt", done_cnt[0], 1);

        // Zero-settle build: one cell per cycle
        for (int k = 0; k < 25; k++) wr(6'(k), 32'(k + 1));
        clr_stats();
        wr(6'd32, 32'h1);
        c0 = ack_cyc;
        bad = 0;
        while (done_cnt[1] == 0 && bad < 100) begin
            @(negedge clk); bad++;
        end
        check("t6_done_seen", done_cnt[1], 1);
        check("t6_done_cyc", done_cyc[1], c0 + 25);
        check("t6_first_chg", first_chg[1], c0 + 1);
        check("t6_min_gap", min_gap[1], 1);
        check("t6_max_gap", max_gap[1], 1);
        check("t6_n_chg", n_chg[1], 25);
        check("t6_multi", multi[1], 0);
        check("t6_cfg", 32'(cfg0 === exp_cfg), 32'd1);
        wait_idle(300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/io_cell_cfg_sequencer.md
Name: io_cell_cfg_sequencer

Overview:
- Owns the per-pad configuration bus of the SoC IO cell frame: NUM_CELLS fields of CONF_WIDTH bits each, covering drive strength, pull and direction controls.
- Software writes staged (shadow) values through a simple register port, then issues a commit.
- On commit the block applies the shadow values to the active configuration one cell at a time, with a programmable settle gap between changed cells, to limit simultaneous-switching noise on the pad ring.
- Sits between the SoC control register bus and the cell_cfg input of the IO cell frame.

Parameters:
- NUM_CELLS, 25, number of IO cells configured; must be 1..32.
- CONF_WIDTH, 5, configuration bits per cell.
- SETTLE_CYCLES, 4, idle clocks after each changed cell is applied; 0 is legal.
- DEFAULT_CFG, 5'b00000, reset value of every shadow and active field; width CONF_WIDTH.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- reg_req  input  1  register access request; held high until reg_ack.
- reg_we  input  1  1 = write, 0 = read; valid while reg_req.
- reg_addr  input  6  word address.
- reg_wdata  input  32  write data.
- reg_rdata  output  32  read data; valid in the reg_ack cycle.
- reg_ack  output  1  single-cycle access completion.
- cell_cfg_o  output  NUM_CELLS*CONF_WIDTH  active configuration; cell k occupies bits [(k+1)*CONF_WIDTH-1 : k*CONF_WIDTH].
- busy_o  output  1  apply sequence in progress.
- done_o  output  1  one-cycle pulse when a sequence completes.

Behaviour:
- Reset (async, rst_n=0):
  - Every shadow and active field is set to DEFAULT_CFG.
  - FSM goes to IDLE; index and counter are cleared.
  - reg_ack, reg_rdata, busy_o, done_o and the err flag are all 0.
  - A reset mid-sequence aborts immediately: cell_cfg_o returns to all DEFAULT_CFG.
- Register handshake:
  - reg_ack is registered and rises on the clock after reg_req is sampled high with reg_ack low.
  - It is high for exactly one cycle, then low for at least one cycle, so back-to-back requests complete every 2 cycles.
  - The access takes effect on the same edge that asserts reg_ack.
- Address map:
  - 0..NUM_CELLS-1: shadow field k. Writes take reg_wdata[CONF_WIDTH-1:0]. Reads return the shadow value, zero-extended.
  - 32 CTRL: writing bit0=1 issues a commit. Reads return 0.
  - 33 STATUS (read-only):
    - bit0 = busy.
    - bit1 = pending: some shadow field differs from its active field.
    - bit2 = err (sticky).
    - bits[12:8] = current index.
    - A read of STATUS clears err on the ack edge; an error event on that same edge wins and leaves err set.
  - Any other address: write ignored, read returns 0, still acked.
- Access while busy:
  - Shadow writes and commits are acked, but have no effect and set err.
  - Reads are always honoured.
- FSM states: IDLE, APPLY, SETTLE.
  - IDLE: a commit write moves to APPLY with idx=0 and busy_o=1 on the ack edge.
  - APPLY, shadow[idx] == active[idx] (unchanged cell):
    - No update and no settle.
    - If idx==NUM_CELLS-1, go to IDLE with done_o pulse; otherwise idx+1 and stay in APPLY.
  - APPLY, shadow[idx] != active[idx] (changed cell):
    - active[idx] <= shadow[idx]; this is visible on cell_cfg_o the cycle after the APPLY cycle.
    - If SETTLE_CYCLES==0, advance as for an unchanged cell.
    - Otherwise load cnt = SETTLE_CYCLES-1 and go to SETTLE.
  - SETTLE: decrement cnt each cycle. At cnt==0, either finish (idx==NUM_CELLS-1: go to IDLE, pulse done_o) or set idx+1 and go to APPLY.
- Outputs and timing:
  - busy_o is high in APPLY and SETTLE, and low in the cycle done_o pulses.
  - At most one active field changes per clock.
  - Latency from the commit ack edge to IDLE is NUM_CELLS + changed_cells*SETTLE_CYCLES cycles.
  - A commit with nothing pending still walks all cells: NUM_CELLS cycles, then done_o.

Test Plan:
- Reset, then read all fields: every shadow field reads DEFAULT_CFG, cell_cfg_o is all zeros, and STATUS reads 0x0000.
- Write shadow[3]=5'h1A and shadow[24]=5'h07, read STATUS (pending=1), commit:
  - cell 3 changes first, and cell 24 changes 21+4 cycles later.
  - Total sequence is 25+2*4=33 cycles.
  - done_o pulses once; pending then reads 0.
- All 25 fields changed with SETTLE_CYCLES=4:
  - At most one field changes per cycle.
  - Consecutive changes are exactly 5 cycles apart.
  - busy_o stays high for 125 cycles.
- Write shadow[0] and commit during busy:
  - Both accesses are acked; the sequence is unaffected and shadow[0] is unchanged.
  - err reads 1, then 0 on a second STATUS read.
- Drop rst_n mid-sequence at idx=10:
  - cell_cfg_o is immediately all DEFAULT_CFG; busy_o=0 and no done_o.
  - After reset release, a commit with no writes completes in 25 cycles.
- SETTLE_CYCLES=0 build, all cells changed: one cell per cycle; done_o fires 25 cycles after the commit ack.
